// File: rtl/ctrl_bus_arbiter.sv
// Two-requester (AES/SHA) bus arbiter: latches the granted instruction word and
// sends it LSB-first, one byte per accepted beat. Define ROUND_ROBIN_EN for round-robin contention.
module ctrl_bus_arbiter #(
  parameter int ADDRW = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             aes_req,
  input  logic [ADDRW+7:0] aes_data,
  output logic             aes_grant,
  input  logic             sha_req,
  input  logic [ADDRW+7:0] sha_data,
  output logic             sha_grant,
  output logic [7:0]       bus_data,
  output logic             bus_valid,
  input  logic             bus_ready,
  output logic             bus_last,
  output logic             bus_owner,
  output logic             busy
);
  localparam int W = ADDRW + 8;
  localparam int NBYTES = W / 8;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t        r_state;
  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_bus_data;
  logic          r_bus_valid;
  logic          r_bus_last;
  logic          r_bus_owner;
  logic          r_busy;
  logic          w_aes_win;
  logic          w_sha_win;
  logic [W-1:0]  w_sel_data;
  logic [W-1:0]  w_shift_next;
`ifdef ROUND_ROBIN_EN
  logic          r_last_sha;
`endif

  assign w_sel_data   = w_sha_win ? sha_data : aes_data;
  assign w_shift_next = r_shift >> 4'd8;

  // Grant selection: only in IDLE and never while reset is asserted
  always_comb begin
    w_aes_win = 1'b0;
    w_sha_win = 1'b0;
    if (rst_n && (r_state == IDLE)) begin
      if (aes_req && sha_req) begin
`ifdef ROUND_ROBIN_EN
        w_aes_win = r_last_sha;
        w_sha_win = ~r_last_sha;
`else
        w_aes_win = 1'b1;
        w_sha_win = 1'b0;
`endif
      end else begin
        w_aes_win = aes_req;
        w_sha_win = sha_req;
      end
    end else begin
      w_aes_win = 1'b0;
      w_sha_win = 1'b0;
    end
  end

  // Arbitration/serializer FSM with registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_bus_data  <= 8'h00;
      r_bus_valid <= 1'b0;
      r_bus_last  <= 1'b0;
      r_bus_owner <= 1'b0;
      r_busy      <= 1'b0;
`ifdef ROUND_ROBIN_EN
      r_last_sha  <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aes_win || w_sha_win) begin
            r_state     <= SEND;
            r_shift     <= w_sel_data;
            r_cnt       <= '0;
            r_bus_data  <= w_sel_data[7:0];
            r_bus_valid <= 1'b1;
            r_bus_last  <= (NBYTES == 1);
            r_bus_owner <= w_sha_win;
            r_busy      <= 1'b1;
`ifdef ROUND_ROBIN_EN
            r_last_sha  <= w_sha_win;
`endif
          end
        end
        SEND: begin
          if (r_bus_valid && bus_ready) begin
            if (r_cnt == LAST_CNT) begin
              r_state     <= IDLE;
              r_bus_data  <= 8'h00;
              r_bus_valid <= 1'b0;
              r_bus_last  <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_shift    <= w_shift_next;
              r_cnt      <= r_cnt + 1'b1;
              r_bus_data <= w_shift_next[7:0];
              r_bus_last <= ((r_cnt + 1'b1) == LAST_CNT);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign aes_grant = w_aes_win;
  assign sha_grant = w_sha_win;
  assign bus_data  = r_bus_data;
  assign bus_valid = r_bus_valid;
  assign bus_last  = r_bus_last;
  assign bus_owner = r_bus_owner;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// Bench for ctrl_bus_arbiter: word-level reference model checked every cycle,
// plus directed scenarios with hand-computed byte/grant expectations.
module tb_ctrl_bus_arbiter;
  localparam int ADDRW = 24;
  localparam int W = ADDRW + 8;
  localparam int NB = W / 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         aes_req = 1'b0;
  logic [W-1:0] aes_data = '0;
  logic         aes_grant;
  logic         sha_req = 1'b0;
  logic [W-1:0] sha_data = '0;
  logic         sha_grant;
  logic [7:0]   bus_data;
  logic         bus_valid;
  logic         bus_ready = 1'b1;
  logic         bus_last;
  logic         bus_owner;
  logic         busy;

  int n_run = 0;
  int n_fail = 0;

  logic [7:0] t1 [4];
  logic [7:0] ta [4];
  logic [7:0] ts [4];

  ctrl_bus_arbiter #(.ADDRW(ADDRW)) dut (
    .clk(clk), .rst_n(rst_n),
    .aes_req(aes_req), .aes_data(aes_data), .aes_grant(aes_grant),
    .sha_req(sha_req), .sha_data(sha_data), .sha_grant(sha_grant),
    .bus_data(bus_data), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_last(bus_last), .bus_owner(bus_owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0b required %0b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_y(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %02h required %02h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a word in flight plus the index of the byte on the bus
  initial begin : model
    logic         m_send;
    logic         m_owner;
    logic         m_last_sha;
    logic [W-1:0] m_word;
    int           m_idx;
    logic         e_ag, e_sg, e_last;
    logic [7:0]   e_data;
    m_send = 1'b0; m_owner = 1'b0; m_last_sha = 1'b1; m_word = '0; m_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_send = 1'b0; m_owner = 1'b0; m_last_sha = 1'b1; m_idx = 0;
        chk_b("rst_aes_grant", aes_grant, 1'b0);
        chk_b("rst_sha_grant", sha_grant, 1'b0);
        chk_b("rst_valid", bus_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_last", bus_last, 1'b0);
        chk_b("rst_owner", bus_owner, 1'b0);
        chk_y("rst_data", bus_data, 8'h00);
      end else begin
        e_ag = 1'b0;
        e_sg = 1'b0;
        if (!m_send) begin
          if (aes_req && sha_req) begin
`ifdef ROUND_ROBIN_EN
            e_ag = m_last_sha;
            e_sg = !m_last_sha;
`else
            e_ag = 1'b1;
`endif
          end else begin
            e_ag = aes_req;
            e_sg = sha_req;
          end
        end
        e_data = m_send ? m_word[8*m_idx +: 8] : 8'h00;
        e_last = m_send && (m_idx == NB - 1);
        chk_b("mdl_aes_grant", aes_grant, e_ag);
        chk_b("mdl_sha_grant", sha_grant, e_sg);
        chk_b("mdl_valid", bus_valid, m_send);
        chk_b("mdl_busy", busy, m_send);
        chk_b("mdl_last", bus_last, e_last);
        chk_b("mdl_owner", bus_owner, m_owner);
        chk_y("mdl_data", bus_data, e_data);
        if (!m_send) begin
          if (e_ag || e_sg) begin
            m_send = 1'b1;
            m_idx = 0;
            m_word = e_ag ? aes_data : sha_data;
            m_owner = e_sg;
            m_last_sha = e_sg;
          end
        end else if (bus_ready) begin
          if (m_idx == NB - 1) m_send = 1'b0;
          else m_idx++;
        end
      end
    end
  end

  initial begin : stim
    t1[0] = 8'hDD; t1[1] = 8'hCC; t1[2] = 8'hBB; t1[3] = 8'hAA;
    ta[0] = 8'h44; ta[1] = 8'h33; ta[2] = 8'h22; ta[3] = 8'h11;
    ts[0] = 8'h88; ts[1] = 8'h77; ts[2] = 8'h66; ts[3] = 8'h55;

    adv(); adv();
    rst_n = 1'b1;
    adv(); adv();

    // AES only, ready held high
    aes_data = 32'hAABBCCDD;
    aes_req = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk_b("t1_aes_grant", aes_grant, 1'b1);
        chk_b("t1_valid_c0", bus_valid, 1'b0);
      end else if (c <= 4) begin
        chk_y("t1_byte", bus_data, t1[c-1]);
        chk_b("t1_last", bus_last, (c == 4));
        chk_b("t1_owner", bus_owner, 1'b0);
      end else begin
        chk_b("t1_idle_valid", bus_valid, 1'b0);
        chk_b("t1_idle_busy", busy, 1'b0);
      end
      adv();
      if (c == 0) aes_req = 1'b0;
    end

    // bus_ready toggling while idle is ignored
    bus_ready = 1'b0;
    adv(); adv();
    bus_ready = 1'b1;

    // Contention, both requests held from reset
    rst_n = 1'b0;
    aes_data = 32'h11223344;
    sha_data = 32'h55667788;
    aes_req = 1'b1;
    sha_req = 1'b1;
    adv(); adv();
    rst_n = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      if (c == 0) chk_b("t2_first_aes", aes_grant, 1'b1);
`ifdef ROUND_ROBIN_EN
      chk_b("t2_sha_grant", sha_grant, (c == 5));
      chk_b("t2_aes_grant", aes_grant, (c == 0) || (c == 10));
      if (c >= 6 && c <= 9) begin
        chk_y("t2_sha_byte", bus_data, ts[c-6]);
        chk_b("t2_sha_owner", bus_owner, 1'b1);
      end
`else
      chk_b("t2_no_sha_grant", sha_grant, 1'b0);
      chk_b("t2_aes_grant", aes_grant, (c % 5) == 0);
      if (c >= 6 && c <= 9) chk_y("t2_aes_again", bus_data, ta[c-6]);
`endif
      if (c >= 1 && c <= 4) begin
        chk_y("t2_aes_byte", bus_data, ta[c-1]);
        chk_b("t2_aes_owner", bus_owner, 1'b0);
      end
      adv();
    end
    aes_req = 1'b0;
    sha_req = 1'b0;
    adv();

    // Backpressure on byte1 for three cycles
    aes_data = 32'hAABBCCDD;
    aes_req = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      bus_ready = !(c >= 2 && c <= 4);
      @(negedge clk);
      if (c >= 1 && c <= 7) begin
        chk_b("t3_valid", bus_valid, 1'b1);
        chk_y("t3_byte", bus_data, (c == 1) ? 8'hDD : (c <= 5) ? 8'hCC : (c == 6) ? 8'hBB : 8'hAA);
        chk_b("t3_last", bus_last, (c == 7));
      end else if (c == 8) begin
        chk_b("t3_done", bus_valid, 1'b0);
      end
      adv();
      if (c == 0) aes_req = 1'b0;
    end
    bus_ready = 1'b1;

    // SHA request arriving mid-word
    aes_data = 32'hAABBCCDD;
    sha_data = 32'h55667788;
    aes_req = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 2) sha_req = 1'b1;
      @(negedge clk);
      chk_b("t4_sha_grant", sha_grant, (c == 5));
      if (c >= 6 && c <= 9) begin
        chk_y("t4_sha_byte", bus_data, ts[c-6]);
        chk_b("t4_owner", bus_owner, 1'b1);
      end
      if (c == 10) chk_b("t4_done", bus_valid, 1'b0);
      adv();
      if (c == 0) aes_req = 1'b0;
      if (c == 5) sha_req = 1'b0;
    end

    // Reset in the middle of a word
    aes_data = 32'hAABBCCDD;
    aes_req = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      if (c == 2) begin
        rst_n = 1'b0;
        aes_req = 1'b1;
      end
      if (c == 4) rst_n = 1'b1;
      @(negedge clk);
      if (c == 1) chk_y("t5_byte0_pre", bus_data, 8'hDD);
      if (c == 2 || c == 3) begin
        chk_b("t5_rst_valid", bus_valid, 1'b0);
        chk_b("t5_rst_busy", busy, 1'b0);
        chk_b("t5_rst_aes_grant", aes_grant, 1'b0);
        chk_b("t5_rst_sha_grant", sha_grant, 1'b0);
      end
      if (c == 4) chk_b("t5_regrant", aes_grant, 1'b1);
      if (c >= 5 && c <= 8) chk_y("t5_restart_byte", bus_data, t1[c-5]);
      if (c == 9) chk_b("t5_done", bus_valid, 1'b0);
      adv();
      if (c == 0 || c == 4) aes_req = 1'b0;
    end

    adv(); adv();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
